// File: rtl/sd3_pkg.sv
// Shared EXE-stage types: ALU op codes, branch conditions, MUL FSM state,
// the EXE/MEM bundle and the single-cycle ALU / branch evaluators.
package sd3_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_XOR = 5'd4,
    OP_SLL = 5'd5,
    OP_SRL = 5'd6,
    OP_SRA = 5'd7,
    OP_SLT = 5'd8,
    OP_MUL = 5'd9
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_ALWAYS = 4'd0,
    BR_EQ     = 4'd1,
    BR_NE     = 4'd2,
    BR_LT     = 4'd3,
    BR_GE     = 4'd4
  } br_cond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] b2;
    logic        mem_we;
    logic        reg_we;
    logic        mem_to_reg;
    logic        br_taken;
    logic [31:0] br_target;
  } ex_mem_t;

  function automatic logic [31:0] alu_calc(
    input logic [4:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic br_eval(
    input logic [3:0]  cond,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic t;
    t = 1'b0;
    unique case (1'b1)
      cond == BR_ALWAYS: t = 1'b1;
      cond == BR_EQ:     t = (a == b);
      cond == BR_NE:     t = (a != b);
      cond == BR_LT:     t = ($signed(a) < $signed(b));
      cond == BR_GE:     t = ($signed(a) >= $signed(b));
      default:           t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/exe_mul_serial.sv
// Bit-serial 32x32 multiplier: one shift-add step per BUSY cycle,
// low 32 product bits valid on `product` while count is 31.
module exe_mul_serial
  import sd3_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [4:0]  count,
  output logic [31:0] product
);

  mul_state_e  state, state_nxt;
  logic [31:0] mcand, mplier, acc;
  logic [4:0]  cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_BUSY;
      ST_BUSY: if (abort || cnt == 5'd31) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_BUSY);
    count   = cnt;
    product = acc + (mplier[0] ? mcand : 32'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == ST_IDLE && start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (busy && abort) begin
      cnt    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// EXE pipeline stage: ALU, branch resolve, EXE/MEM register.
// Define EXE_STAGE_MUL_EN to build in the multi-cycle serial MUL.
module exe_stage
  import sd3_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        EXE_UC_Enable_Ula,
  input  logic        EXE_UC_ULA_Fonte,
  input  logic [4:0]  EXE_INSTRUC_R_OPULA,
  input  logic        EXE_INSTRUC_BRANCH_OP,
  input  logic [3:0]  EXE_INSTRUC_BRANCH_COND,
  input  logic [31:0] EXE_PC_NEXT_INS_OUT,
  input  logic [31:0] EXE_EXTENSOR_DE_SINAL_OUT,
  input  logic [31:0] EXE_B_R_Out_1,
  input  logic [31:0] EXE_B_R_Out_2,
  input  logic        EXE_UC_MEM_DADO_WE,
  input  logic        EXE_UC_B_R_Signal_Write,
  input  logic        EXE_UC_MemPara_B_Reg,
  input  logic        EXE_Flush,
  output logic [31:0] MEM_ULA_Result,
  output logic [31:0] MEM_B_R_Out_2,
  output logic        MEM_UC_MEM_DADO_WE,
  output logic        MEM_UC_B_R_Signal_Write,
  output logic        MEM_UC_MemPara_B_Reg,
  output logic        MEM_Branch_Taken,
  output logic [31:0] MEM_Branch_Target,
  output logic        EXE_Stall
);

  ex_mem_t     cur, mem_d, mem_q;
  logic [31:0] op_b;

  assign op_b = EXE_UC_ULA_Fonte ? EXE_EXTENSOR_DE_SINAL_OUT : EXE_B_R_Out_2;

  always_comb begin
    cur            = '0;
    cur.result     = EXE_UC_Enable_Ula ?
                     alu_calc(EXE_INSTRUC_R_OPULA, EXE_B_R_Out_1, op_b) : 32'd0;
    cur.b2         = EXE_B_R_Out_2;
    cur.mem_we     = EXE_UC_MEM_DADO_WE;
    cur.reg_we     = EXE_UC_B_R_Signal_Write;
    cur.mem_to_reg = EXE_UC_MemPara_B_Reg;
    cur.br_taken   = EXE_INSTRUC_BRANCH_OP &
                     br_eval(EXE_INSTRUC_BRANCH_COND, EXE_B_R_Out_1, EXE_B_R_Out_2);
    cur.br_target  = EXE_PC_NEXT_INS_OUT + EXE_EXTENSOR_DE_SINAL_OUT;
  end

`ifdef EXE_STAGE_MUL_EN
  logic        is_mul, mul_start, mul_busy, mul_last;
  logic [4:0]  mul_cnt;
  logic [31:0] mul_prod;
  ex_mem_t     mul_hold;

  assign is_mul    = EXE_UC_Enable_Ula && (EXE_INSTRUC_R_OPULA == OP_MUL);
  assign mul_start = is_mul && !EXE_Flush && !mul_busy;
  assign mul_last  = mul_busy && (mul_cnt == 5'd31);

  // Gated by reset so the stall drops immediately, even with a MUL presented
  assign EXE_Stall = reset &&
                     (mul_start || (mul_busy && !EXE_Flush && !mul_last));

  exe_mul_serial u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .abort   (EXE_Flush),
    .a       (EXE_B_R_Out_1),
    .b       (op_b),
    .busy    (mul_busy),
    .count   (mul_cnt),
    .product (mul_prod)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         mul_hold <= '0;
    else if (mul_start) mul_hold <= cur;
  end

  always_comb begin
    mem_d = cur;
    if (EXE_Flush) begin
      mem_d = '0;
    end else if (mul_busy) begin
      mem_d = '0;
      if (mul_last) begin
        mem_d        = mul_hold;
        mem_d.result = mul_prod;
      end
    end else if (is_mul) begin
      mem_d = '0;
    end
  end
`else
  assign EXE_Stall = 1'b0;

  always_comb begin
    mem_d = cur;
    if (EXE_Flush) mem_d = '0;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign MEM_ULA_Result          = mem_q.result;
  assign MEM_B_R_Out_2           = mem_q.b2;
  assign MEM_UC_MEM_DADO_WE      = mem_q.mem_we;
  assign MEM_UC_B_R_Signal_Write = mem_q.reg_we;
  assign MEM_UC_MemPara_B_Reg    = mem_q.mem_to_reg;
  assign MEM_Branch_Taken        = mem_q.br_taken;
  assign MEM_Branch_Target       = mem_q.br_target;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage; scoreboard of expected EXE/MEM words.
// Exercises the MUL path when EXE_STAGE_MUL_EN is defined.
module tb_exe_stage;

`ifdef EXE_STAGE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clock, reset;
  logic        en, fonte, bop, we, sw, mp, flush;
  logic [4:0]  op;
  logic [3:0]  cond;
  logic [31:0] pc, ext, a, b2;
  logic [31:0] r_res, r_b2, r_tgt;
  logic        r_we, r_sw, r_mp, r_tk, stall;

  typedef struct {
    bit          bub;
    logic [99:0] v;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  exe_stage dut (
    .clock                     (clock),
    .reset                     (reset),
    .EXE_UC_Enable_Ula         (en),
    .EXE_UC_ULA_Fonte          (fonte),
    .EXE_INSTRUC_R_OPULA       (op),
    .EXE_INSTRUC_BRANCH_OP     (bop),
    .EXE_INSTRUC_BRANCH_COND   (cond),
    .EXE_PC_NEXT_INS_OUT       (pc),
    .EXE_EXTENSOR_DE_SINAL_OUT (ext),
    .EXE_B_R_Out_1             (a),
    .EXE_B_R_Out_2             (b2),
    .EXE_UC_MEM_DADO_WE        (we),
    .EXE_UC_B_R_Signal_Write   (sw),
    .EXE_UC_MemPara_B_Reg      (mp),
    .EXE_Flush                 (flush),
    .MEM_ULA_Result            (r_res),
    .MEM_B_R_Out_2             (r_b2),
    .MEM_UC_MEM_DADO_WE        (r_we),
    .MEM_UC_B_R_Signal_Write   (r_sw),
    .MEM_UC_MemPara_B_Reg      (r_mp),
    .MEM_Branch_Taken          (r_tk),
    .MEM_Branch_Target         (r_tgt),
    .EXE_Stall                 (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [99:0] obs();
    return {r_res, r_b2, r_we, r_sw, r_mp, r_tk, r_tgt};
  endfunction

  function automatic exp_t model();
    exp_t        e;
    logic [31:0] bb, res;
    logic        c;
    e.bub = 1'b0;
    e.v   = '0;
    if (flush) begin
      e.bub = 1'b1;
      return e;
    end
    bb  = fonte ? ext : b2;
    res = 32'd0;
    if (en) begin
      case (op)
        5'd0: res = a + bb;
        5'd1: res = a - bb;
        5'd2: res = a & bb;
        5'd3: res = a | bb;
        5'd4: res = a ^ bb;
        5'd5: res = a << bb[4:0];
        5'd6: res = a >> bb[4:0];
        5'd7: res = $unsigned($signed(a) >>> bb[4:0]);
        5'd8: res = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
        default: res = 32'd0;
      endcase
    end
    case (cond)
      4'd0: c = 1'b1;
      4'd1: c = (a == b2);
      4'd2: c = (a != b2);
      4'd3: c = ($signed(a) < $signed(b2));
      4'd4: c = ($signed(a) >= $signed(b2));
      default: c = 1'b0;
    endcase
    e.v = {res, b2, we, sw, mp, bop & c, pc + ext};
    return e;
  endfunction

  task automatic set_in(input logic e_, input logic f_, input logic [4:0] o_,
                        input logic [31:0] a_, input logic [31:0] b_,
                        input logic [31:0] x_);
    en = e_; fonte = f_; op = o_; a = a_; b2 = b_; ext = x_;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0; flush = 1'b0;
    bop = 1'b1; cond = 4'd0; pc = 32'h40;
    we = 1'b1; sw = 1'b1; mp = 1'b1;
    set_in(1'b1, 1'b0, 5'd0, 32'd1, 32'd2, 32'd4);
    #3;
    n_tests++;
    if (obs() !== 100'd0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got %h stall %b exp 0", obs(), stall);
    end
    @(posedge clock); #1;
    n_tests++;
    if (obs() !== 100'd0) begin
      n_fail++;
      $display("FAIL reset_hold got %h exp 0", obs());
    end
    @(negedge clock);
    reset = 1'b1;
    sbq.push_back(model());
    @(posedge clock); #1;
    e = sbq.pop_front();
    n_tests++;
    if (obs() !== e.v) begin
      n_fail++;
      $display("FAIL reset_first_capture got %h exp %h", obs(), e.v);
    end
  endtask

  task automatic test_alu();
    exp_t e;
    bop = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 16; k++) begin
        if (MUL_EN && k == 9) continue;
        we = k[0]; sw = k[1]; mp = k[2];
        if (p == 0)
          set_in(1'b1, 1'b0, k[4:0], 32'hFFFF_FFFF, 32'd1, 32'h7);
        else if (p == 1)
          set_in(1'b1, 1'b1, k[4:0], 32'h8000_0000, 32'h1234_5678, 32'd4);
        else
          set_in(1'b1, k[3], k[4:0], $urandom, $urandom, $urandom);
        sbq.push_back(model());
        @(posedge clock); #1;
        e = sbq.pop_front();
        n_tests++;
        if (obs() !== e.v || stall !== 1'b0) begin
          n_fail++;
          $display("FAIL alu p%0d op%0d got %h stall %b exp %h",
                   p, k, obs(), stall, e.v);
        end
        n_tests++;
        if (p == 0 && k == 0 && r_res !== 32'h0) begin
          n_fail++;
          $display("FAIL add_wrap got %h exp 00000000", r_res);
        end else if (p == 1 && k == 7 && r_res !== 32'hF800_0000) begin
          n_fail++;
          $display("FAIL sra_imm got %h exp f8000000", r_res);
        end
      end
    end
  endtask

  task automatic test_enable_off();
    exp_t e;
    we = 1'b1; sw = 1'b1; mp = 1'b1; bop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b0, k[4:0], 32'hABCD_0000 + k, 32'h55, 32'h3);
      sbq.push_back(model());
      @(posedge clock); #1;
      e = sbq.pop_front();
      n_tests++;
      if (obs() !== e.v || r_res !== 32'd0) begin
        n_fail++;
        $display("FAIL enable_off op%0d got %h exp %h", k, obs(), e.v);
      end
    end
  endtask

  task automatic test_branch();
    exp_t        e;
    logic [31:0] av[3];
    logic [31:0] bv[3];
    av = '{32'hFFFF_FFFF, 32'd5, 32'd0};
    bv = '{32'd0, 32'd5, 32'hFFFF_FFFF};
    we = 1'b0; sw = 1'b0; mp = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 8; c++) begin
        bop = (c != 7) || (s != 0);
        cond = c[3:0];
        pc = 32'h100 + 32'(s);
        set_in(1'b1, 1'b0, 5'd0, av[s], bv[s], 32'h20);
        sbq.push_back(model());
        @(posedge clock); #1;
        e = sbq.pop_front();
        n_tests++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL branch s%0d c%0d got %h exp %h", s, c, obs(), e.v);
        end
        n_tests++;
        if (s == 0 && c == 3 && {r_tk, r_tgt} !== {1'b1, 32'h120}) begin
          n_fail++;
          $display("FAIL branch_lt got %b %h exp 1 00000120", r_tk, r_tgt);
        end
      end
    end
    bop = 1'b0; cond = 4'd0; pc = 32'd0;
  endtask

  task automatic test_flush();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      flush = (k == 0);
      we = 1'b1; sw = 1'b1; mp = 1'b0; bop = 1'b1; cond = 4'd0;
      set_in(1'b1, 1'b0, 5'd0, 32'd10, 32'd20, 32'd8);
      sbq.push_back(model());
      @(posedge clock); #1;
      e = sbq.pop_front();
      n_tests++;
      if (e.bub ? ({r_we, r_sw, r_tk} !== 3'b000) : (obs() !== e.v)) begin
        n_fail++;
        $display("FAIL flush k%0d got %h exp %h bub %0d", k, obs(), e.v, e.bub);
      end
    end
    flush = 1'b0; bop = 1'b0;
  endtask

`ifdef EXE_STAGE_MUL_EN
  task automatic test_mul();
    exp_t e;
    int   hi;
    flush = 1'b0; bop = 1'b0; cond = 4'd0; pc = 32'd0;
    we = 1'b1; sw = 1'b1; mp = 1'b1;
    set_in(1'b1, 1'b0, 5'd9, 32'h0001_2345, 32'h0000_0100, 32'd0);
    #1;
    hi = (stall === 1'b1) ? 1 : 0;
    for (int j = 0; j < 32; j++) sbq.push_back('{1'b1, 100'd0});
    e.bub = 1'b0;
    e.v = {32'h0123_4500, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0};
    sbq.push_back(e);
    for (int j = 1; j <= 32; j++) begin
      @(posedge clock); #1;
      we = 1'b1; sw = 1'b1;
      set_in(1'b1, 1'b0, 5'd0, $urandom, $urandom, $urandom);
      #1;
      if (stall === 1'b1) hi++;
      e = sbq.pop_front();
      n_tests++;
      if ({r_we, r_sw, r_tk} !== 3'b000 || stall !== (j <= 31)) begin
        n_fail++;
        $display("FAIL mul_bubble e%0d got %b%b%b stall %b", j, r_we, r_sw, r_tk, stall);
      end
    end
    n_tests++;
    if (hi != 32) begin
      n_fail++;
      $display("FAIL mul_stall_cycles got %0d exp 32", hi);
    end
    @(posedge clock); #1;
    e = sbq.pop_front();
    n_tests++;
    if (obs() !== e.v) begin
      n_fail++;
      $display("FAIL mul_product got %h exp %h", obs(), e.v);
    end
    set_in(1'b1, 1'b0, 5'd1, 32'd100, 32'd1, 32'd0);
    #1;
    sbq.push_back(model());
    @(posedge clock); #1;
    e = sbq.pop_front();
    n_tests++;
    if (obs() !== e.v || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_after got %h stall %b exp %h", obs(), stall, e.v);
    end
  endtask

  task automatic test_mul_flush();
    exp_t e;
    set_in(1'b1, 1'b0, 5'd9, 32'd7, 32'd9, 32'd0);
    @(posedge clock); #1;
    set_in(1'b1, 1'b0, 5'd0, 32'd1, 32'd1, 32'd0);
    repeat (10) @(posedge clock);
    #1;
    flush = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy_stall got %b exp 0", stall);
    end
    sbq.push_back(model());
    @(posedge clock); #1;
    flush = 1'b0;
    e = sbq.pop_front();
    n_tests++;
    if ({r_we, r_sw, r_tk} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_busy_bubble got %b%b%b exp 000", r_we, r_sw, r_tk);
    end
    set_in(1'b1, 1'b0, 5'd0, 32'd40, 32'd2, 32'd0);
    #1;
    sbq.push_back(model());
    @(posedge clock); #1;
    e = sbq.pop_front();
    n_tests++;
    if (obs() !== e.v || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy_idle got %h stall %b exp %h", obs(), stall, e.v);
    end
    flush = 1'b1;
    set_in(1'b1, 1'b0, 5'd9, 32'd3, 32'd3, 32'd0);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_issue_stall got %b exp 0", stall);
    end
    @(posedge clock); #1;
    flush = 1'b0;
    set_in(1'b1, 1'b0, 5'd2, 32'hF0, 32'h3C, 32'd0);
    #1;
    sbq.push_back(model());
    @(posedge clock); #1;
    e = sbq.pop_front();
    n_tests++;
    if (obs() !== e.v || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_issue_nobusy got %h stall %b exp %h", obs(), stall, e.v);
    end
  endtask
`else
  task automatic test_mul_disabled();
    exp_t e;
    we = 1'b1; sw = 1'b0; mp = 1'b1; bop = 1'b0;
    set_in(1'b1, 1'b0, 5'd9, 32'h0001_2345, 32'h100, 32'd0);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_off_stall got %b exp 0", stall);
    end
    sbq.push_back(model());
    @(posedge clock); #1;
    e = sbq.pop_front();
    n_tests++;
    if (obs() !== e.v || r_res !== 32'd0) begin
      n_fail++;
      $display("FAIL mul_off_result got %h exp %h", obs(), e.v);
    end
  endtask
`endif

  task automatic test_back_to_back();
    exp_t       e;
    logic [4:0] o;
    for (int k = 0; k < 24; k++) begin
      o = 5'($urandom_range(0, 15));
      if (MUL_EN && o == 5'd9) o = 5'd4;
      flush = ($urandom_range(0, 4) == 0);
      we = $urandom; sw = $urandom; mp = $urandom; bop = $urandom;
      cond = 4'($urandom_range(0, 7));
      pc = $urandom;
      set_in($urandom, $urandom, o, $urandom, $urandom, $urandom);
      sbq.push_back(model());
      @(posedge clock); #1;
      e = sbq.pop_front();
      n_tests++;
      if (e.bub ? ({r_we, r_sw, r_tk} !== 3'b000) : (obs() !== e.v)) begin
        n_fail++;
        $display("FAIL b2b k%0d got %h exp %h bub %0d", k, obs(), e.v, e.bub);
      end
    end
    flush = 1'b0; bop = 1'b0; cond = 4'd0; pc = 32'd0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    we = 1'b1; sw = 1'b1; mp = 1'b1; bop = 1'b1; cond = 4'd0; pc = 32'h10;
`ifdef EXE_STAGE_MUL_EN
    set_in(1'b1, 1'b0, 5'd9, 32'd11, 32'd13, 32'd0);
    @(posedge clock); #1;
    repeat (5) @(posedge clock);
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_reset stall %b exp 1", stall);
    end
`else
    set_in(1'b1, 1'b0, 5'd0, 32'd11, 32'd13, 32'd4);
    @(posedge clock); #1;
`endif
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 100'd0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got %h stall %b exp 0", obs(), stall);
    end
    @(negedge clock);
    reset = 1'b1;
    set_in(1'b1, 1'b0, 5'd0, 32'd11, 32'd13, 32'd4);
    sbq.push_back(model());
    @(posedge clock); #1;
    e = sbq.pop_front();
    n_tests++;
    if (obs() !== e.v || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_add got %h stall %b exp %h", obs(), stall, e.v);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_enable_off();
    test_branch();
    test_flush();
`ifdef EXE_STAGE_MUL_EN
    test_mul();
    test_mul_flush();
`else
    test_mul_disabled();
`endif
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got %0d exp 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
